icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Sits between the program counter / fetch logic, which drives the fetch address and read enable, and the instruction side of the memory controller.
- Returns instructions in the same cycle on a hit.
- On a miss, runs a single-outstanding-request refill FSM against memory and stalls the datapath until the fill completes.

Parameters:
- SETS, 16, number of frames; must be a power of two, 2..256.
- IDX_W, 4, log2(SETS); index = imemaddr[IDX_W+1:2].
- TAG_W, 26, 30-IDX_W; tag = imemaddr[31:IDX_W+2].

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset, sampled on rising CLK.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  fetch address (word_t) from PC; bits[1:0] ignored.
- flush  input  1  invalidate all frames (driven on halt).
- ihit  output  1  imemload valid this cycle; PC may advance.
- imemload  output  32  instruction word.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  word-aligned address to memory controller.
- iwait  input  1  memory busy; iwait=0 while iREN=1 means iload is valid this cycle.
- iload  input  32  data returned by memory.

Behaviour:
- Storage: per frame, valid (1b), tag (TAG_W), data (32b). Only valid bits are reset; tag/data are don't-care when invalid.
- Reset (nRST=0 at edge):
  - all valid bits cleared; FSM goes to IDLE; miss_addr cleared to 0.
  - Outputs combinational from state: ihit=0, iREN=0, iaddr=0, imemload=0 while IDLE with no request.
- Hit (IDLE, imemREN=1, valid[idx]=1 and tag[idx]==addr tag):
  - ihit=1 and imemload=data[idx] in the same cycle (0-cycle latency).
  - No state change; iREN=0.
- Miss (IDLE, imemREN=1, no hit):
  - ihit=0.
  - At the edge: miss_addr <= {imemaddr[31:2],2'b00}; FSM -> FETCH.
- FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0.
  - While iwait=1: remain in FETCH.
  - When iwait=0: at the edge, write valid=1, tag and data=iload into frame miss_addr index; FSM -> IDLE.
  - The re-presented address then hits on the following cycle.
  - Miss latency = memory wait cycles + 2 cycles to ihit.
- imemREN deasserted or imemaddr changed during FETCH: the fill completes using the latched miss_addr (memory protocol forbids abandoning a request). No ihit is produced for the new address until back in IDLE.
- imemREN=0 in IDLE: ihit=0, imemload=0, no state change.
- flush=1:
  - All valid bits cleared at the edge.
  - In FETCH, the fill is aborted (no frame write) and FSM -> IDLE.
  - flush has priority over hit, miss, and fill write in the same cycle; ihit is forced to 0 while flush=1.
- Conflict: a fill overwrites the existing frame at the same index unconditionally (no replacement choice).
- Reset mid-FETCH: FSM -> IDLE, iREN drops in the next cycle, and the fill is discarded.

Optional Feature:
ICACHE_STATS_EN
- Defined:
  - Adds outputs hit_count [31:0] and miss_count [31:0], both reset to 0 and cleared by flush.
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then imemREN=1, imemaddr=32'h0000_0000, memory iwait=1 for 3 cycles then iload=32'h2001_0005:
  - iREN=1 with iaddr=0 for 4 cycles, then FSM returns to IDLE.
  - Next cycle ihit=1, imemload=32'h2001_0005.
- Same address re-fetched: ihit=1 the same cycle, iREN stays 0.
- Conflict: fill 0x0000_0004, then fetch 0x0000_0044 (same index 1, different tag):
  - miss; frame 1 is overwritten.
  - A refetch of 0x0000_0004 misses again.
- Address change mid-FETCH: miss on 0x0000_0010, then switch imemaddr to 0x0000_0020 while iwait=1:
  - iaddr stays 0x0000_0010; frame 4 is filled.
  - 0x20 then misses separately.
- flush asserted in FETCH on the same cycle iwait=0:
  - no frame write; FSM -> IDLE; all valid bits are 0.
  - A refetch of the prior hit address misses.
- nRST=0 during FETCH: iREN=0 the next cycle and all frames invalid; with ICACHE_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache with a single-outstanding refill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, state_n;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [31:0]       data [SETS];
  logic [31:0]       miss_addr;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              lookup_hit, start_miss, fill_we;
  logic              unused_addr_bits;

  assign req_idx          = imemaddr[IDX_W+1:2];
  assign req_tag          = imemaddr[31:IDX_W+2];
  assign fill_idx         = miss_addr[IDX_W+1:2];
  assign lookup_hit       = valid[req_idx] && (tags[req_idx] == req_tag);
  assign unused_addr_bits = ^imemaddr[1:0];

  // flush outranks hit, miss and fill; a fill always lands at the latched miss address
  always_comb begin
    state_n    = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    start_miss = 1'b0;
    fill_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (imemREN && !flush) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data[req_idx];
          end else begin
            start_miss = 1'b1;
            state_n    = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (flush) begin
          state_n = IDLE;
        end else if (!iwait) begin
          fill_we = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        valid <= '0;
      end else if (fill_we) begin
        valid[fill_idx] <= 1'b1;
      end
      if (start_miss) begin
        miss_addr <= {imemaddr[31:2], 2'b00};
      end
    end
  end

  // Tag/data carry no reset; only the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (nRST && fill_we) begin
      tags[fill_idx] <= miss_addr[31:IDX_W+2];
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_miss && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: vector table with an expectation queue,
// plus randomized-latency refill sequences (and counter checks when ICACHE_STATS_EN is defined).
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_direct #(.SETS(16), .IDX_W(4), .TAG_W(26)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst;
    logic        ren;
    logic [31:0] addr;
    logic        fl;
    logic        iw;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] iaddr;
  } exp_t;

  vec_t         vecs[$];
  exp_t         sb_q[$];
  logic [31:0]  data_q[$];
  int unsigned  checks   = 0;
  int unsigned  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic nrst, input logic ren, input logic [31:0] addr, input logic fl,
                     input logic iw, input logic [31:0] ld, input logic e_hit,
                     input logic [31:0] e_load, input logic e_ren, input logic [31:0] e_iaddr);
    vec_t v;
    v.nrst = nrst; v.ren = ren; v.addr = addr; v.fl = fl; v.iw = iw; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_iaddr = e_iaddr;
    vecs.push_back(v);
  endtask

  // Drive right after the edge, sample well before the next one.
  task automatic drive(input logic nrst, input logic ren, input logic [31:0] addr,
                       input logic fl, input logic iw, input logic [31:0] ld);
    @(posedge CLK);
    #1;
    nRST = nrst; imemREN = ren; imemaddr = addr; flush = fl; iwait = iw; iload = ld;
    #3;
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Fetch one address against a memory that stalls 'waits' cycles; bounded by a cycle budget.
  task automatic fetch_mem(input string name, input logic [31:0] a, input int unsigned waits,
                           input bit expect_miss);
    int unsigned cyc = 0;
    int unsigned wcnt = 0;
    bit          done = 0;
    bit          addr_checked = 0;
    logic [31:0] exp_d;
    data_q.push_back(data_of(a));
    while (!done && cyc < 40) begin
      @(posedge CLK);
      #1;
      nRST = 1'b1; imemREN = 1'b1; imemaddr = a; flush = 1'b0;
      if (iREN) begin
        iwait = (wcnt < waits);
        iload = data_of(iaddr);
        wcnt++;
        if (!addr_checked) begin
          chk({name, "_iaddr"}, iaddr, a);
          addr_checked = 1;
        end
      end else begin
        iwait = 1'b1;
        iload = '0;
      end
      #3;
      cyc++;
      if (ihit) done = 1;
    end
    exp_d = data_q.pop_front();
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_data"}, imemload, exp_d);
      chk({name, "_latency"}, cyc, expect_miss ? waits + 3 : 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
    repeat (2) @(posedge CLK);

    //   nrst ren addr          fl iw load           hit load           ren iaddr
    add(1, 0, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         1, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         1, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         1, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         1, 32'h2001_0005, 0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         1, 32'h2001_0005, 0, 32'h00);
    // conflict on index 1
    add(1, 1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0004, 0, 0, 32'hAAAA_0004, 0, 32'h0,         1, 32'h04);
    add(1, 1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'hAAAA_0004, 0, 32'h00);
    add(1, 1, 32'h0000_0044, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0044, 0, 0, 32'hBBBB_0044, 0, 32'h0,         1, 32'h44);
    add(1, 1, 32'h0000_0044, 0, 1, 32'h0,         1, 32'hBBBB_0044, 0, 32'h00);
    add(1, 1, 32'h0000_0004, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0004, 0, 0, 32'hAAAA_0004, 0, 32'h0,         1, 32'h04);
    add(1, 1, 32'h0000_0004, 0, 1, 32'h0,         1, 32'hAAAA_0004, 0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         1, 32'h2001_0005, 0, 32'h00);
    // address change mid-fetch
    add(1, 1, 32'h0000_0010, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0020, 0, 1, 32'h0,         0, 32'h0,         1, 32'h10);
    add(1, 1, 32'h0000_0020, 0, 0, 32'hCCCC_0010, 0, 32'h0,         1, 32'h10);
    add(1, 1, 32'h0000_0020, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0020, 0, 0, 32'hDDDD_0020, 0, 32'h0,         1, 32'h20);
    add(1, 1, 32'h0000_0020, 0, 1, 32'h0,         1, 32'hDDDD_0020, 0, 32'h00);
    add(1, 1, 32'h0000_0010, 0, 1, 32'h0,         1, 32'hCCCC_0010, 0, 32'h00);
    add(1, 0, 32'h0000_0010, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    // flush on the completing fetch cycle
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0030, 1, 0, 32'hEEEE_0030, 0, 32'h0,         1, 32'h30);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h00);
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0030, 0, 0, 32'hEEEE_0030, 0, 32'h0,         1, 32'h30);
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         1, 32'hEEEE_0030, 0, 32'h00);
    add(1, 1, 32'h0000_0030, 1, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         0, 32'h0,         1, 32'h30);
    // reset in the middle of a fetch
    add(0, 1, 32'h0000_0030, 0, 1, 32'h0,         0, 32'h0,         1, 32'h30);
    add(1, 0, 32'h0000_0030, 0, 0, 32'h1234_5678, 0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0030, 0, 0, 32'h5555_0030, 0, 32'h0,         1, 32'h30);
    add(1, 1, 32'h0000_0030, 0, 1, 32'h0,         1, 32'h5555_0030, 0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 0, 32'h2001_0005, 0, 32'h0,         1, 32'h00);
    add(1, 1, 32'h0000_0000, 0, 1, 32'h0,         1, 32'h2001_0005, 0, 32'h00);
    add(1, 1, 32'h0000_0003, 0, 1, 32'h0,         1, 32'h2001_0005, 0, 32'h00);
    add(1, 0, 32'h0000_0000, 0, 1, 32'h0,         0, 32'h0,         0, 32'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].nrst, vecs[i].ren, vecs[i].addr, vecs[i].fl, vecs[i].iw, vecs[i].ld);
      e.hit = vecs[i].e_hit; e.load = vecs[i].e_load; e.ren = vecs[i].e_ren; e.iaddr = vecs[i].e_iaddr;
      sb_q.push_back(e);
      e = sb_q.pop_front();
      chk($sformatf("v%0d_ihit", i), {31'd0, ihit}, {31'd0, e.hit});
      chk($sformatf("v%0d_imemload", i), imemload, e.load);
      chk($sformatf("v%0d_iREN", i), {31'd0, iREN}, {31'd0, e.ren});
      chk($sformatf("v%0d_iaddr", i), iaddr, e.iaddr);
    end

    // refills against a memory with random stall lengths
    fetch_mem("m0", 32'h0000_0100, $urandom_range(0, 5), 1);
    fetch_mem("m1", 32'h0000_0104, $urandom_range(0, 5), 1);
    fetch_mem("m2", 32'h0000_0100, 0, 0);
    fetch_mem("m3", 32'h0000_0200, $urandom_range(0, 5), 1);
    fetch_mem("m4", 32'h0000_0100, 0, 1);
    fetch_mem("m5", 32'h0000_0104, 0, 0);

`ifdef ICACHE_STATS_EN
    drive(1, 0, 32'h0, 1, 1, 32'h0);
    drive(1, 0, 32'h0, 0, 1, 32'h0);
    chk("stat_flush_hits", hit_count, 32'd0);
    chk("stat_flush_misses", miss_count, 32'd0);
    fetch_mem("s0", 32'h0000_0040, 2, 1);
    fetch_mem("s1", 32'h0000_0040, 0, 0);
    fetch_mem("s2", 32'h0000_0040, 0, 0);
    drive(1, 0, 32'h0, 0, 1, 32'h0);
    chk("stat_hits", hit_count, 32'd3);
    chk("stat_misses", miss_count, 32'd1);
    drive(1, 1, 32'h0000_0080, 0, 1, 32'h0);
    drive(0, 1, 32'h0000_0080, 0, 1, 32'h0);
    chk("stat_rst_iREN_before", {31'd0, iREN}, 32'd1);
    drive(1, 0, 32'h0000_0080, 0, 0, 32'h0);
    chk("stat_rst_iREN_after", {31'd0, iREN}, 32'd0);
    chk("stat_rst_hits", hit_count, 32'd0);
    chk("stat_rst_misses", miss_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
